// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between instruction fetch
// (IF) and load/store (MEM). Each granted transaction walks IDLE -> ISSUE ->
// (WAIT) -> RESP and finishes with a one-cycle ready pulse to its owner.
//
// Handshake: a requester raises *_req with stable address/data and keeps it
// up until its *_ready pulse (fetch may also drop on if_kill). It may drop or
// change the request in the cycle after the pulse; that cycle is always IDLE
// and is the one that samples the new request.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    input  logic                if_kill,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_ready,
    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    input  logic [DATA_W/8-1:0] dm_wstrb,
    output logic [DATA_W-1:0]   dm_rdata,
    output logic                dm_ready,
    output logic                mem_en,
    output logic [DATA_W/8-1:0] mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                pipe_stall
);

    localparam int STRB_W = DATA_W / 8;
    localparam int SW_W   = $clog2(STARVE_MAX + 1);
    localparam int LAT_W  = $clog2(MEM_LAT + 1);
    localparam logic [SW_W-1:0]  STARVE_LIM = SW_W'(STARVE_MAX);
    localparam logic [LAT_W-1:0] LAT_INIT   = LAT_W'(MEM_LAT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                owner_dm_q, owner_dm_d;   // 1 = data port owns the transaction
    logic                store_q, store_d;
    logic                kill_q, kill_d;
    logic [LAT_W-1:0]    lat_q, lat_d;
    logic [SW_W-1:0]     starve_q, starve_d;
    logic                mem_en_q, mem_en_d;
    logic [STRB_W-1:0]   mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;
    logic                if_ready_q, if_ready_d;
    logic                dm_ready_q, dm_ready_d;

    logic fetch_ok;
    logic force_fetch;
    logic kill_hit;

    // A fetch killed in IDLE is simply not granted; the starve limit only
    // overrides data priority when fetch is actually eligible.
    assign fetch_ok    = if_req & ~if_kill;
    assign force_fetch = fetch_ok & (starve_q == STARVE_LIM);
    assign kill_hit    = if_kill & ~owner_dm_q;

    // Next-state and registered-output logic for the transaction sequencer.
    always_comb begin
        state_d     = state_q;
        owner_dm_d  = owner_dm_q;
        store_d     = store_q;
        kill_d      = kill_q;
        lat_d       = lat_q;
        starve_d    = starve_q;
        mem_en_d    = 1'b0;
        mem_we_d    = '0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_ready_d  = 1'b0;
        dm_ready_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                kill_d = 1'b0;
                if (dm_req && !force_fetch) begin
                    owner_dm_d  = 1'b1;
                    store_d     = dm_we;
                    mem_addr_d  = dm_addr;
                    mem_wdata_d = dm_wdata;
                    mem_en_d    = 1'b1;
                    mem_we_d    = dm_we ? dm_wstrb : '0;
                    if (if_req) begin
                        starve_d = (starve_q == STARVE_LIM) ? STARVE_LIM : starve_q + SW_W'(1);
                    end else begin
                        starve_d = '0;
                    end
                    state_d = ST_ISSUE;
                end else if (fetch_ok) begin
                    owner_dm_d = 1'b0;
                    store_d    = 1'b0;
                    mem_addr_d = if_addr;
                    mem_en_d   = 1'b1;
                    starve_d   = '0;
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                kill_d = kill_q | kill_hit;
                if (store_q) begin
                    dm_ready_d = 1'b1;
                    state_d    = ST_RESP;
                end else begin
                    lat_d   = LAT_INIT;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                kill_d = kill_q | kill_hit;
                lat_d  = lat_q - LAT_W'(1);
                if (lat_q == LAT_W'(1)) begin
                    state_d = ST_RESP;
                    if (owner_dm_q) begin
                        dm_rdata_d = mem_rdata;
                        dm_ready_d = 1'b1;
                    end else if (!(kill_q || kill_hit)) begin
                        if_rdata_d = mem_rdata;
                        if_ready_d = 1'b1;
                    end
                end
            end
            ST_RESP: begin
                kill_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            owner_dm_q  <= 1'b0;
            store_q     <= 1'b0;
            kill_q      <= 1'b0;
            lat_q       <= '0;
            starve_q    <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_ready_q  <= 1'b0;
            dm_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_dm_q  <= owner_dm_d;
            store_q     <= store_d;
            kill_q      <= kill_d;
            lat_q       <= lat_d;
            starve_q    <= starve_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            if_ready_q  <= if_ready_d;
            dm_ready_q  <= dm_ready_d;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign if_ready  = if_ready_q;
    assign dm_ready  = dm_ready_q;

    // Stall is combinational so the pipeline freezes in the same cycle a
    // request appears; a killed fetch no longer holds the front end.
    assign pipe_stall = (if_req & ~if_ready_q & ~if_kill) | (dm_req & ~dm_ready_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter (MEM_LAT=2, STARVE_MAX=4).
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam logic [31:0] G = 32'hBAD0_BAD0;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic          if_req, if_kill, dm_req, dm_we;
  logic [AW-1:0] if_addr, dm_addr, mem_addr;
  logic [DW-1:0] dm_wdata, mem_rdata, if_rdata, dm_rdata, mem_wdata;
  logic [SW-1:0] dm_wstrb, mem_we;
  logic          if_ready, dm_ready, mem_en, pipe_stall;

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(2), .STARVE_MAX(4)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
    .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_wstrb(dm_wstrb),
    .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .pipe_stall(pipe_stall)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] got_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        ir;  logic [31:0] ia; logic ik;
    logic        dr;  logic dw; logic [31:0] da; logic [31:0] dwd; logic [3:0] ds;
    logic [31:0] mr;
    logic        een; logic [3:0] ewe; logic [31:0] ead; logic [31:0] ewd;
    logic        eir; logic [31:0] eid; logic edr; logic [31:0] edd; logic es;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(
    input logic ir, input logic [31:0] ia, input logic ik,
    input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dwd,
    input logic [3:0] ds, input logic [31:0] mr,
    input logic een, input logic [3:0] ewe, input logic [31:0] ead, input logic [31:0] ewd,
    input logic eir, input logic [31:0] eid, input logic edr, input logic [31:0] edd,
    input logic es);
    vec_t r;
    r.ir = ir; r.ia = ia; r.ik = ik; r.dr = dr; r.dw = dw; r.da = da; r.dwd = dwd;
    r.ds = ds; r.mr = mr; r.een = een; r.ewe = ewe; r.ead = ead; r.ewd = ewd;
    r.eir = eir; r.eid = eid; r.edr = edr; r.edd = edd; r.es = es;
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  // All tasks start and end just after a rising edge (+1).
  task automatic idle_inputs();
    if_req = 0; if_addr = '0; if_kill = 0;
    dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0; dm_wstrb = '0;
    mem_rdata = G;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < vecs.size(); i++) begin
      if_req = vecs[i].ir; if_addr = vecs[i].ia; if_kill = vecs[i].ik;
      dm_req = vecs[i].dr; dm_we = vecs[i].dw; dm_addr = vecs[i].da;
      dm_wdata = vecs[i].dwd; dm_wstrb = vecs[i].ds; mem_rdata = vecs[i].mr;
      @(negedge clk);
      check($sformatf("%s[%0d] mem_en", tag, i), 32'(mem_en), 32'(vecs[i].een));
      check($sformatf("%s[%0d] mem_we", tag, i), 32'(mem_we), 32'(vecs[i].ewe));
      if (vecs[i].een)
        check($sformatf("%s[%0d] mem_addr", tag, i), mem_addr, vecs[i].ead);
      if (vecs[i].een && vecs[i].ewe != 4'h0)
        check($sformatf("%s[%0d] mem_wdata", tag, i), mem_wdata, vecs[i].ewd);
      check($sformatf("%s[%0d] if_ready", tag, i), 32'(if_ready), 32'(vecs[i].eir));
      check($sformatf("%s[%0d] if_rdata", tag, i), if_rdata, vecs[i].eid);
      check($sformatf("%s[%0d] dm_ready", tag, i), 32'(dm_ready), 32'(vecs[i].edr));
      check($sformatf("%s[%0d] dm_rdata", tag, i), dm_rdata, vecs[i].edd);
      check($sformatf("%s[%0d] pipe_stall", tag, i), 32'(pipe_stall), 32'(vecs[i].es));
      next_cycle();
    end
    vecs.delete();
  endtask

  // Uncontended fetch: strobe in cycle 1, ready in cycle 4.
  task automatic do_fetch(input string tag, input logic [31:0] addr, input logic [31:0] data);
    int en_cyc;
    int rdy_cyc;
    en_cyc = -1;
    rdy_cyc = -1;
    if_req = 1; if_addr = addr; mem_rdata = data;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (mem_en && en_cyc < 0) begin
        en_cyc = k;
        check({tag, " mem_addr"}, mem_addr, addr);
      end
      if (if_ready) begin
        rdy_cyc = k;
        check({tag, " if_rdata"}, if_rdata, data);
      end
      next_cycle();
      if (rdy_cyc >= 0) break;
    end
    if_req = 0;
    check({tag, " mem_en cycle"}, 32'(en_cyc), 32'd1);
    check({tag, " if_ready cycle"}, 32'(rdy_cyc), 32'd4);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " mem_en"}, 32'(mem_en), 0);
    check({tag, " mem_we"}, 32'(mem_we), 0);
    check({tag, " mem_addr"}, mem_addr, 0);
    check({tag, " mem_wdata"}, mem_wdata, 0);
    check({tag, " if_rdata"}, if_rdata, 0);
    check({tag, " dm_rdata"}, dm_rdata, 0);
    check({tag, " if_ready"}, 32'(if_ready), 0);
    check({tag, " dm_ready"}, 32'(dm_ready), 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main test ----------------
  initial begin
    int n_en;
    int n_rdy;
    int waited;
    logic drop_if;

    idle_inputs();
    rst = 0;
    @(negedge clk);
    check_all_zero("reset");
    next_cycle();
    rst = 1;
    next_cycle();

    // Fetch from 0x100, memory data valid in cycle 3 only.
    vecs.push_back(v(1,32'h100,0, 0,0,0,0,0, G,            0,0,0,0,             0,0,0,0, 1));
    vecs.push_back(v(1,32'h100,0, 0,0,0,0,0, G,            1,0,32'h100,0,       0,0,0,0, 1));
    vecs.push_back(v(1,32'h100,0, 0,0,0,0,0, G,            0,0,0,0,             0,0,0,0, 1));
    vecs.push_back(v(1,32'h100,0, 0,0,0,0,0, 32'h13,       0,0,0,0,             0,0,0,0, 1));
    vecs.push_back(v(1,32'h100,0, 0,0,0,0,0, G,            0,0,0,0,             1,32'h13,0,0, 0));
    vecs.push_back(v(0,0,0,       0,0,0,0,0, G,            0,0,0,0,             0,32'h13,0,0, 0));
    run_table("fetch");

    // Store word to 0x2004; dm_rdata must not move.
    vecs.push_back(v(0,0,0, 1,1,32'h2004,32'hDEADBEEF,4'hF, G,  0,0,0,0,                      0,32'h13,0,0, 1));
    vecs.push_back(v(0,0,0, 1,1,32'h2004,32'hDEADBEEF,4'hF, G,  1,4'hF,32'h2004,32'hDEADBEEF, 0,32'h13,0,0, 1));
    vecs.push_back(v(0,0,0, 1,1,32'h2004,32'hDEADBEEF,4'hF, G,  0,0,0,0,                      0,32'h13,1,0, 0));
    vecs.push_back(v(0,0,0, 0,0,0,0,0,                      G,  0,0,0,0,                      0,32'h13,0,0, 0));
    run_table("store");

    // Contention: load from 0x2000 wins, fetch 0x104 follows.
    vecs.push_back(v(1,32'h104,0, 1,0,32'h2000,0,0, G,            0,0,0,0,        0,32'h13,0,0, 1));
    vecs.push_back(v(1,32'h104,0, 1,0,32'h2000,0,0, G,            1,0,32'h2000,0, 0,32'h13,0,0, 1));
    vecs.push_back(v(1,32'h104,0, 1,0,32'h2000,0,0, G,            0,0,0,0,        0,32'h13,0,0, 1));
    vecs.push_back(v(1,32'h104,0, 1,0,32'h2000,0,0, 32'h11112222, 0,0,0,0,        0,32'h13,0,0, 1));
    vecs.push_back(v(1,32'h104,0, 1,0,32'h2000,0,0, G,            0,0,0,0,        0,32'h13,1,32'h11112222, 1));
    vecs.push_back(v(1,32'h104,0, 0,0,0,0,0,        G,            0,0,0,0,        0,32'h13,0,32'h11112222, 1));
    vecs.push_back(v(1,32'h104,0, 0,0,0,0,0,        G,            1,0,32'h104,0,  0,32'h13,0,32'h11112222, 1));
    vecs.push_back(v(1,32'h104,0, 0,0,0,0,0,        G,            0,0,0,0,        0,32'h13,0,32'h11112222, 1));
    vecs.push_back(v(1,32'h104,0, 0,0,0,0,0,        32'h33334444, 0,0,0,0,        0,32'h13,0,32'h11112222, 1));
    vecs.push_back(v(1,32'h104,0, 0,0,0,0,0,        G,            0,0,0,0,        1,32'h33334444,0,32'h11112222, 0));
    vecs.push_back(v(0,0,0,       0,0,0,0,0,        G,            0,0,0,0,        0,32'h33334444,0,32'h11112222, 0));
    run_table("contend");

    // Starvation: both held; expect D D D D F D.
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h2008);
    exp_q.push_back(32'h300);
    exp_q.push_back(32'h2008);
    got_q.delete();
    if_req = 1; if_addr = 32'h300;
    dm_req = 1; dm_we = 1; dm_addr = 32'h2008; dm_wdata = 32'hCAFE0001; dm_wstrb = 4'hF;
    mem_rdata = 32'h55;
    drop_if = 0;
    for (int k = 0; k < 60 && got_q.size() < 6; k++) begin
      @(negedge clk);
      if (mem_en) got_q.push_back(mem_addr);
      if (if_ready) drop_if = 1;
      next_cycle();
      if (drop_if) if_req = 0;
    end
    waited = 0;
    while (!dm_ready && waited < 10) begin
      @(negedge clk);
      if (dm_ready) begin
        next_cycle();
        break;
      end
      next_cycle();
      waited++;
    end
    idle_inputs();
    next_cycle();
    check("starve grant count", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) check($sformatf("starve grant[%0d]", i), got_q[i], exp_q[i]);
    end
    check("starve if_rdata", if_rdata, 32'h55);
    exp_q.delete();

    // Flush: kill during WAIT of a fetch to 0x180.
    n_en = 0;
    n_rdy = 0;
    mem_rdata = 32'h77;
    for (int k = 0; k < 10; k++) begin
      if_req = (k <= 2); if_addr = 32'h180; if_kill = (k == 2);
      @(negedge clk);
      if (mem_en) n_en++;
      if (if_ready) n_rdy++;
      if (k == 2) check("flush stall during kill", 32'(pipe_stall), 0);
      next_cycle();
    end
    if_kill = 0; if_req = 0;
    check("flush mem_en count", 32'(n_en), 1);
    check("flush if_ready count", 32'(n_rdy), 0);
    check("flush if_rdata held", if_rdata, 32'h55);
    do_fetch("post-flush fetch", 32'h200, 32'h99);
    next_cycle();

    // Reset asserted in the middle of a load's WAIT.
    dm_req = 1; dm_we = 0; dm_addr = 32'h2010; mem_rdata = 32'h12345678;
    next_cycle();
    next_cycle();
    #2;
    rst = 0;
    dm_req = 0;
    #1;
    check_all_zero("reset mid-wait");
    next_cycle();
    next_cycle();
    rst = 1;
    n_en = 0;
    n_rdy = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (mem_en) n_en++;
      if (if_ready || dm_ready) n_rdy++;
      next_cycle();
    end
    check("post-reset mem_en count", 32'(n_en), 0);
    check("post-reset ready count", 32'(n_rdy), 0);
    check("post-reset dm_rdata", dm_rdata, 0);
    do_fetch("post-reset fetch", 32'h204, 32'hABCD);
    next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
